// File: rtl/actmem_read_controller.sv
// Activation memory read controller: rotating-bank pixel fetch, 8b->5-trit decode, 3-entry output FIFO.
// Optional build macro ACTMEM_READ_ZEROPAD_EN adds req_pad_i for zero-padding pixels.
module actmem_trit_decoder (
  input  logic [7:0]      byte_i,
  output logic [4:0][1:0] trits_o
);
  logic [7:0] v;
  logic [7:0] d;
  always_comb begin
    v = byte_i;
    d = '0;
    trits_o = '0;
    // base-3 digit 0/1/2 maps to trit 0/+1/-1
    for (int k = 0; k < 5; k++) begin
      d = v % 8'd3;
      v = v / 8'd3;
      trits_o[k] = (d == 8'd1) ? 2'b01 : (d == 8'd2) ? 2'b11 : 2'b00;
    end
  end
endmodule

module actmem_read_controller #(
  parameter int N_I                    = 128,
  parameter int WEIGHT_STAGGER         = 8,
  parameter int K                      = 3,
  parameter int IMAGEWIDTH             = 224,
  parameter int IMAGEHEIGHT            = 224,
  parameter int NUMBANKS               = K * WEIGHT_STAGGER,
  parameter int EFFECTIVETRITSPERWORD  = N_I / WEIGHT_STAGGER,
  parameter int PHYSICALTRITSPERWORD   = (EFFECTIVETRITSPERWORD + 4) / 5 * 5,
  parameter int PHYSICALBITSPERWORD    = PHYSICALTRITSPERWORD / 5 * 8,
  parameter int ACTMEMBANKADDRESSDEPTH = $clog2(((IMAGEWIDTH * IMAGEHEIGHT * N_I + NUMBANKS - 1) / NUMBANKS
                                                 + EFFECTIVETRITSPERWORD - 1) / EFFECTIVETRITSPERWORD),
  parameter int FIFODEPTH              = 3
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_ni,
  input  logic                                                      latch_new_layer_i,
  input  logic [$clog2(NUMBANKS)-1:0]                               layer_offset_i,
  input  logic [$clog2(NUMBANKS)-1:0]                               layer_stride_i,
  input  logic [$clog2(N_I):0]                                      layer_ni_i,
  input  logic                                                      req_valid_i,
`ifdef ACTMEM_READ_ZEROPAD_EN
  input  logic                                                      req_pad_i,
`endif
  output logic                                                      req_ready_o,
  output logic [0:NUMBANKS-1]                                       read_enable_o,
  output logic [0:NUMBANKS-1][ACTMEMBANKADDRESSDEPTH-1:0]           read_addr_o,
  input  logic [0:NUMBANKS-1][PHYSICALBITSPERWORD-1:0]              rdata_i,
  output logic [0:WEIGHT_STAGGER-1][EFFECTIVETRITSPERWORD-1:0][1:0] acts_o,
  output logic                                                      valid_o,
  input  logic                                                      ready_i
);
  localparam int BW     = $clog2(NUMBANKS);
  localparam int AW     = ACTMEMBANKADDRESSDEPTH;
  localparam int NIW    = $clog2(N_I) + 1;
  localparam int CW     = $clog2(WEIGHT_STAGGER + 1);
  localparam int GROUPS = PHYSICALTRITSPERWORD / 5;
  localparam int PW     = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CNTW   = $clog2(FIFODEPTH + 1);

  typedef logic [0:WEIGHT_STAGGER-1][EFFECTIVETRITSPERWORD-1:0][1:0] acts_t;

  logic                               init_q, init_d, pending_q, pending_d, pad_q, pad_d;
  logic [BW-1:0]                      bank_q, bank_d, stride_q, stride_d;
  logic [AW-1:0]                      addr_q, addr_d;
  logic [NIW-1:0]                     ni_q, ni_d;
  logic [CW-1:0]                      nreads_q, nreads_d, numreads;
  logic [0:WEIGHT_STAGGER-1][BW-1:0]  banks_q, banks_d;
  acts_t                              fifo_q [FIFODEPTH];
  acts_t                              fifo_d [FIFODEPTH];
  logic [PW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]                    count_q, count_d;

  logic        req_pad, accept, push, pop;
  logic [15:0] nr_sum, idx, tot;
  logic [BW-1:0] bk;
  acts_t       decoded;
  logic [0:WEIGHT_STAGGER-1][GROUPS-1:0][4:0][1:0] dec_trits;

`ifdef ACTMEM_READ_ZEROPAD_EN
  assign req_pad = req_pad_i;
`else
  assign req_pad = 1'b0;
`endif

  always_comb begin
    nr_sum = (16'(ni_q) + 16'(EFFECTIVETRITSPERWORD - 1)) / 16'(EFFECTIVETRITSPERWORD);
    if (nr_sum == 16'd0)                        numreads = CW'(1);
    else if (nr_sum > 16'(WEIGHT_STAGGER))      numreads = CW'(WEIGHT_STAGGER);
    else                                        numreads = CW'(nr_sum);
  end

  assign valid_o     = (count_q != '0);
  assign acts_o      = valid_o ? fifo_q[rptr_q] : '0;
  assign req_ready_o = init_q & ~latch_new_layer_i & ((32'(pending_q) + 32'(count_q)) < FIFODEPTH);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = pending_q & ~latch_new_layer_i;
  assign pop         = valid_o & ready_i;

  // Request side: bank strobes and rotation counters
  always_comb begin
    init_d = init_q; bank_d = bank_q; addr_d = addr_q; stride_d = stride_q; ni_d = ni_q;
    pending_d = 1'b0; pad_d = pad_q; nreads_d = nreads_q; banks_d = banks_q;
    read_enable_o = '0; read_addr_o = '0;
    idx = '0; bk = '0; tot = '0;
    if (accept) begin
      for (int j = 0; j < WEIGHT_STAGGER; j++) begin
        if (j < int'(numreads)) begin
          idx = 16'(bank_q) + 16'(j) * 16'(stride_q);
          bk  = BW'(idx % 16'(NUMBANKS));
          banks_d[j] = bk;
          if (!req_pad) begin
            read_enable_o[bk] = 1'b1;
            read_addr_o[bk]   = addr_q + AW'(idx / 16'(NUMBANKS));
          end
        end
      end
      tot = 16'(bank_q) + 16'(numreads) * 16'(stride_q);
      if (!req_pad) begin
        bank_d = BW'(tot % 16'(NUMBANKS));
        addr_d = addr_q + AW'(tot / 16'(NUMBANKS));
      end
      nreads_d = numreads; pad_d = req_pad; pending_d = 1'b1;
    end
    if (latch_new_layer_i) begin
      init_d = 1'b1; bank_d = layer_offset_i; addr_d = '0;
      stride_d = layer_stride_i; ni_d = layer_ni_i; pending_d = 1'b0; pad_d = 1'b0;
    end
  end

  for (genvar j = 0; j < WEIGHT_STAGGER; j++) begin : g_word
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      actmem_trit_decoder u_dec (
        .byte_i  (rdata_i[banks_q[j]][8*g +: 8]),
        .trits_o (dec_trits[j][g])
      );
    end
  end

  // Trits above EFFECTIVETRITSPERWORD are storage padding and are dropped
  always_comb begin
    decoded = '0;
    for (int j = 0; j < WEIGHT_STAGGER; j++)
      if (j < int'(nreads_q) && !pad_q)
        for (int t = 0; t < EFFECTIVETRITSPERWORD; t++)
          decoded[j][t] = dec_trits[j][t / 5][t % 5];
  end

  always_comb begin
    fifo_d = fifo_q; wptr_d = wptr_q; rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = decoded;
      wptr_d = (32'(wptr_q) == FIFODEPTH - 1) ? '0 : wptr_q + PW'(1);
    end
    if (pop) rptr_d = (32'(rptr_q) == FIFODEPTH - 1) ? '0 : rptr_q + PW'(1);
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    if (latch_new_layer_i) begin
      count_d = '0; wptr_d = '0; rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b0; pending_q <= 1'b0; pad_q <= 1'b0;
      bank_q <= '0; addr_q <= '0; stride_q <= BW'(1); ni_q <= NIW'(N_I);
      nreads_q <= '0; banks_q <= '0;
      wptr_q <= '0; rptr_q <= '0; count_q <= '0;
      for (int i = 0; i < FIFODEPTH; i++) fifo_q[i] <= '0;
    end else begin
      init_q <= init_d; pending_q <= pending_d; pad_q <= pad_d;
      bank_q <= bank_d; addr_q <= addr_d; stride_q <= stride_d; ni_q <= ni_d;
      nreads_q <= nreads_d; banks_q <= banks_d;
      wptr_q <= wptr_d; rptr_q <= rptr_d; count_q <= count_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_actmem_read_controller.sv
// Bench for actmem_read_controller: random trit memory, linear-position reference model, in-order scoreboard.
module tb_actmem_read_controller;
  localparam int NB = 24, WS = 8, ET = 16, PBW = 32, AW = 15;

  typedef logic [0:WS-1][ET-1:0][1:0] acts_t;
  typedef struct { int t; acts_t a; } item_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic latch_new_layer_i = 1'b0, req_valid_i = 1'b0, ready_i = 1'b0, req_ready_o, valid_o;
  logic [4:0] layer_offset_i = '0, layer_stride_i = 5'd1;
  logic [7:0] layer_ni_i = 8'd128;
  logic [0:NB-1] read_enable_o;
  logic [0:NB-1][AW-1:0] read_addr_o;
  logic [0:NB-1][PBW-1:0] rdata_i;
  acts_t acts_o;

  actmem_read_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .latch_new_layer_i(latch_new_layer_i),
    .layer_offset_i(layer_offset_i), .layer_stride_i(layer_stride_i), .layer_ni_i(layer_ni_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .read_enable_o(read_enable_o),
    .read_addr_o(read_addr_o), .rdata_i(rdata_i), .acts_o(acts_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  logic [19:0][1:0] tmem [NB][64];

  function automatic logic [31:0] enc(input logic [19:0][1:0] t);
    logic [31:0] w;
    int v, p, d;
    w = '0;
    for (int g = 0; g < 4; g++) begin
      v = 0; p = 1;
      for (int k = 0; k < 5; k++) begin
        d = (t[g*5+k] == 2'b01) ? 1 : (t[g*5+k] == 2'b11) ? 2 : 0;
        v += d * p; p *= 3;
      end
      w[8*g +: 8] = 8'(v);
    end
    return w;
  endfunction

  // Bank memory: one-cycle read latency, garbage on unread banks
  always @(posedge clk_i)
    for (int b = 0; b < NB; b++)
      rdata_i[b] <= read_enable_o[b] ? enc(tmem[b][read_addr_o[b][5:0]]) : 32'($urandom);

  int n_chk = 0, n_fail = 0, cycn = 0, n_acc = 0;
  bit m_init = 0;
  longint m_lin = 0;
  int m_str = 1, m_ni = 128;
  item_t q[$];
  logic [0:NB-1] last_en;
  logic [0:NB-1][AW-1:0] last_addr;
  logic last_v;

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(input bit rv, input bit rdy, input bit lat, input int off, input int str, input int ni);
    logic [0:NB-1] exp_en;
    logic [AW-1:0] exp_addr [NB];
    bit exp_rdy, exp_v, acc;
    item_t it;
    longint p;
    int nr, b, a;
    req_valid_i = rv; ready_i = rdy; latch_new_layer_i = lat;
    layer_offset_i = 5'(off); layer_stride_i = 5'(str); layer_ni_i = 8'(ni);
    #1;
    last_en = read_enable_o; last_addr = read_addr_o; last_v = valid_o;
    if (rv && req_ready_o) n_acc++;
    exp_rdy = m_init && !lat && (q.size() < 3);
    chk("req_ready", req_ready_o, exp_rdy);
    exp_v = (q.size() > 0) && (q[0].t <= cycn);
    chk("valid", valid_o, exp_v);
    if (exp_v) chk("acts", acts_o, q[0].a);
    else       chk("acts_idle", acts_o, '0);
    exp_en = '0;
    acc = rv && exp_rdy;
    if (acc) begin
      nr = (m_ni + ET - 1) / ET;
      if (nr < 1) nr = 1;
      if (nr > WS) nr = WS;
      it.t = cycn + 2;
      it.a = '0;
      for (int j = 0; j < nr; j++) begin
        p = m_lin + longint'(j * m_str);
        b = int'(p % NB);
        a = int'((p / NB) % 32768);
        exp_en[b] = 1'b1;
        exp_addr[b] = AW'(a);
        it.a[j] = tmem[b][a % 64][15:0];
      end
      m_lin += longint'(nr * m_str);
      q.push_back(it);
    end
    chk("rd_en", read_enable_o, exp_en);
    for (int i = 0; i < NB; i++)
      if (exp_en[i]) chk($sformatf("rd_addr%0d", i), read_addr_o[i], exp_addr[i]);
    if (exp_v && rdy) void'(q.pop_front());
    if (lat) begin
      q.delete(); m_init = 1; m_lin = off; m_str = str; m_ni = ni;
    end
    @(posedge clk_i); #1;
    latch_new_layer_i = 1'b0;
    cycn++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1, 0, 0, 1, 128);
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 64; a++)
        for (int t = 0; t < 20; t++)
          case ($urandom_range(0, 2))
            0: tmem[b][a][t] = 2'b00;
            1: tmem[b][a][t] = 2'b01;
            default: tmem[b][a][t] = 2'b11;
          endcase

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_acts", acts_o, '0);
    chk("rst_en", read_enable_o, '0);
    chk("rst_addr", read_addr_o, '0);
    rst_ni = 1'b1;

    // requests before any latch are ignored
    repeat (10) cyc(1, 1, 0, 0, 1, 128);

    // offset 0, stride 1, full width
    cyc(0, 1, 1, 0, 1, 128);
    cyc(1, 1, 0, 0, 1, 128); chk("t2_req0", last_en, 24'hFF0000);
    cyc(1, 1, 0, 0, 1, 128); chk("t2_req1", last_en, 24'h00FF00);
    cyc(1, 1, 0, 0, 1, 128); chk("t2_req2", last_en, 24'h0000FF);
    cyc(1, 1, 0, 0, 1, 128); chk("t2_req3", last_en, 24'hFF0000); chk("t2_addr", last_addr[0], 15'd1);
    idle(4);

    // bank wrap with address increment
    cyc(0, 1, 1, 20, 1, 128);
    cyc(1, 1, 0, 0, 1, 128); chk("t3_req0", last_en, 24'hF0000F);
    chk("t3_addr20", last_addr[20], 15'd0); chk("t3_addr0", last_addr[0], 15'd1);
    cyc(1, 1, 0, 0, 1, 128); chk("t3_req1", last_en, 24'h0FF000); chk("t3_addr4", last_addr[4], 15'd1);
    idle(4);

    // stride 3, two words per pixel
    cyc(0, 1, 1, 0, 3, 32);
    cyc(1, 1, 0, 0, 1, 128); chk("t4_req0", last_en, 24'h900000);
    cyc(1, 1, 0, 0, 1, 128); chk("t4_req1", last_en, 24'h024000);
    idle(4);

    // backpressure: only FIFODEPTH requests outstanding
    cyc(0, 1, 1, 5, 1, 128);
    n_acc = 0;
    repeat (8) cyc(1, 0, 0, 0, 1, 128);
    chk("t5_accepts", n_acc, 3);
    idle(6);

    // relatch with 2 buffered and 1 in flight
    cyc(0, 1, 1, 0, 1, 128);
    repeat (3) cyc(1, 0, 0, 0, 1, 128);
    cyc(0, 0, 1, 7, 1, 64);
    cyc(0, 1, 0, 0, 1, 128); chk("t6_flush", last_v, 1'b0);
    cyc(1, 1, 0, 0, 1, 128); chk("t6_newbank", last_en, 24'h01E000);
    idle(4);

    // random traffic with occasional relatches
    repeat (300) begin
      if ($urandom_range(0, 39) == 0)
        cyc(0, $urandom_range(0, 1), 1, $urandom_range(0, 23), 2 * $urandom_range(0, 11) + 1,
            $urandom_range(1, 128));
      else
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0, 0, 1, 128);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/actmem_read_controller.md
Name: actmem_read_controller

Overview:
Fetches activation words from the K*WEIGHT_STAGGER activation memory banks for one output pixel per request. Decodes each 8-bit/5-trit packed group back to 2-bit trits, drops excess trits, and delivers one pixel's input-channel vector to the compute pipeline over a valid/ready handshake. It is the read-side counterpart of the activation writeback path and uses the same bank rotation: layer offset, stride, and bank wrap with address increment.

Parameters:
N_I, 128, input channels per pixel (max)
WEIGHT_STAGGER, 8, words per pixel at full N_I
K, 3, kernel size; NUMBANKS = K*WEIGHT_STAGGER
IMAGEWIDTH, 224, max image width
IMAGEHEIGHT, 224, max image height
EFFECTIVETRITSPERWORD, N_I/WEIGHT_STAGGER, useful trits per word
PHYSICALTRITSPERWORD, ceil(EFFECTIVETRITSPERWORD/5)*5, stored trits per word
PHYSICALBITSPERWORD, PHYSICALTRITSPERWORD/5*8, bank word width
ACTMEMBANKADDRESSDEPTH, $clog2(ceil(ceil(IMAGEWIDTH*IMAGEHEIGHT*N_I/NUMBANKS)/EFFECTIVETRITSPERWORD)), bank address width
FIFODEPTH, 3, output buffer entries

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
latch_new_layer_i  in  1  load layer config, flush
layer_offset_i  in  $clog2(NUMBANKS)  starting bank
layer_stride_i  in  $clog2(NUMBANKS)  bank stride between words (>=1)
layer_ni_i  in  $clog2(N_I)+1  input channels of layer
req_valid_i  in  1  pixel read request
req_ready_o  out  1  request accepted when both high
read_enable_o  out  [0:NUMBANKS-1]  per-bank read strobe
read_addr_o  out  [0:NUMBANKS-1][ACTMEMBANKADDRESSDEPTH-1:0]  per-bank address
rdata_i  in  [0:NUMBANKS-1][PHYSICALBITSPERWORD-1:0]  bank data, 1 cycle after strobe
acts_o  out  [0:WEIGHT_STAGGER-1][EFFECTIVETRITSPERWORD-1:0][1:0]  decoded trits, word j at index j
valid_o  out  1  acts_o valid
ready_i  in  1  consumer ready

Behaviour:
- Reset: init_q=0, bankcounter=0, addresscounter=0, stride=1, ni=N_I, pending_q=0, FIFO empty. All outputs 0: req_ready_o=0, valid_o=0, acts_o=0, read_enable_o=0, read_addr_o=0.
- Latch: on latch_new_layer_i, set init_q=1, bankcounter=layer_offset_i, addresscounter=0, and register stride and ni. Flush FIFO and pending_q; in-flight data is discarded. req_ready_o is forced 0 in the latch cycle.
- numreads = ceil(ni_q/EFFECTIVETRITSPERWORD), clamped to 1..WEIGHT_STAGGER.
- req_ready_o = init_q & ~latch_new_layer_i & (pending_q + fifo_count < FIFODEPTH). There is no combinational path from ready_i.
- Accept (cycle T):
  - For j in 0..numreads-1: idx = bankcounter + j*stride; bank = idx % NUMBANKS; read_enable_o[bank]=1.
  - read_addr_o[bank] = addresscounter + idx/NUMBANKS.
  - Update: bankcounter <= (bankcounter + numreads*stride) % NUMBANKS; addresscounter <= addresscounter + (bankcounter + numreads*stride)/NUMBANKS.
  - Record the bank list in the in-flight register; pending_q <= 1.
  - Non-accepted cycles drive no strobes.
- T+1: sample rdata_i. Word j comes from its recorded bank. Each 8-bit group goes through a decoder instance (8b to 5 trits), and the top PHYSICAL-EFFECTIVE trits are dropped. Words j >= numreads read as 0. Push the result to the FIFO. pending_q clears unless a new accept occurs.
- T+2: valid_o=1 at the earliest. acts_o is the FIFO head and is held stable while valid_o & ~ready_i. Pop on valid_o & ready_i.
- Throughput: 1 pixel/cycle with ready_i=1.
- Ordering: strict in order.
- Addresses wrap modulo 2^ACTMEMBANKADDRESSDEPTH with no error.
- Simultaneous push and pop: count unchanged.
- Requests before the first latch are never accepted.

Optional Feature:
ACTMEM_READ_ZEROPAD_EN
- Defined: adds input req_pad_i (1b), sampled with the request. A padded request issues no bank reads and does not advance the counters. It pushes an all-zero acts vector with the same T+2 latency and keeps ordering relative to real requests.
- Undefined: the port is absent and every request reads memory.

Test Plan:
1. Reset, then req_valid_i=1 with no latch -> req_ready_o=0, all outputs 0 for 10 cycles.
2. Latch offset=0, stride=1, ni=128; four back-to-back requests -> strobes on banks 0-7, 8-15, 16-23 at addr 0, then banks 0-7 at addr 1. valid_o at T+2 each; four consecutive valid beats.
3. Latch offset=20, stride=1, ni=128; one request -> banks 20-23 at addr 0 and banks 0-3 at addr 1. Next request starts at bank 4, addr 1.
4. Latch offset=0, stride=3, ni=32 (numreads=2) -> banks 0 and 3. Next request -> banks 6 and 9. acts_o words 2-7 are zero.
5. Memory preloaded via the encoder model with random trits; ready_i=0 and continuous requests -> exactly 3 accepts, then req_ready_o=0. Release ready_i -> outputs match the original trits in order.
6. Latch mid-stream with 2 items in the FIFO and 1 pending -> valid_o=0 the next cycle, stale data never emitted, counters at the new offset.
